clk_en_sequencer: RTL and testbench

Controller that sequences a lab datapath through a single registered clock-enable output. It turns three debounced pushbutton levels into enable pulses in one of three modes:
- single-step: one pulse per press.
- free-run: periodic pulses at a programmable rate.
- burst: N pulses, then stop.

It sits between the board buttons and any datapath gated by clk_en, and replaces per-button one-pulse logic with one arbitrated source.

---
 rtl/clk_en_sequencer_if.sv | 31 +++
 rtl/clk_en_sequencer.sv | 139 +++++++++++++
 tb/tb_clk_en_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_sequencer_if.sv
// Button, rate and status bundle for clk_en_sequencer.
// master drives requests; slave (the sequencer) drives enable/status.
interface clk_en_sequencer_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             step_pb;
  logic             run_pb;
  logic             burst_pb;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] burst_len;
  logic             halt;
  logic             clk_en;
  logic             running;
  logic             burst_busy;
  logic [CNT_W-1:0] step_count;

  modport master (
    output step_pb, run_pb, burst_pb,
    output div_val, burst_len, halt,
    input  clk_en, running, burst_busy,
    input  step_count
  );

  modport slave (
    input  step_pb, run_pb, burst_pb,
    input  div_val, burst_len, halt,
    output clk_en, running, burst_busy,
    output step_count
  );
endinterface

// File: rtl/clk_en_sequencer.sv
// Single-step / free-run / burst clock-enable sequencer.
// STEP_COUNT_SAT_EN: step_count saturates instead of wrapping.
module clk_en_sequencer #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  clk_en_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       pb_q, pb_d;
  logic             arm_q, arm_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             run_st_q, run_st_d;
  logic             bsy_q, bsy_d;
  logic             e_step, e_run, e_burst;
  logic             hit;

  // First cycle after reset is masked so held buttons need a re-press
  assign pb_d    = {bus.burst_pb, bus.run_pb, bus.step_pb};
  assign arm_d   = 1'b1;
  assign e_step  = arm_q & bus.step_pb & ~pb_q[0];
  assign e_run   = arm_q & bus.run_pb & ~pb_q[1];
  assign e_burst = arm_q & bus.burst_pb & ~pb_q[2];
  assign hit     = (tick_q == div_q);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick_d   = tick_q;
    rem_d    = rem_q;
    clk_en_d = 1'b0;
    if (bus.halt) begin
      state_d = IDLE;
      tick_d  = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (e_run) begin
            state_d = RUN;
            div_d   = bus.div_val;
            tick_d  = '0;
          end else if (e_burst &&
                       bus.burst_len != '0) begin
            state_d = BURST;
            div_d   = bus.div_val;
            rem_d   = bus.burst_len;
            tick_d  = '0;
          end else if (e_step) begin
            clk_en_d = 1'b1;
          end
        end
        RUN: begin
          if (e_run) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (hit) begin
            clk_en_d = 1'b1;
            tick_d   = '0;
          end else begin
            tick_d = tick_q + DIV_W'(1);
          end
        end
        BURST: begin
          if (e_run) begin
            state_d = IDLE;
            rem_d   = '0;
            tick_d  = '0;
          end else if (hit) begin
            clk_en_d = 1'b1;
            tick_d   = '0;
            rem_d    = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1))
              state_d = IDLE;
          end else begin
            tick_d = tick_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run_st_d = (state_d == RUN);
    bsy_d    = (state_d == BURST);
    cnt_d    = cnt_q;
`ifdef STEP_COUNT_SAT_EN
    if (clk_en_q && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
`else
    if (clk_en_q)
      cnt_d = cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pb_q     <= '0;
      arm_q    <= 1'b0;
      div_q    <= '0;
      tick_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      run_st_q <= 1'b0;
      bsy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pb_q     <= pb_d;
      arm_q    <= arm_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      run_st_q <= run_st_d;
      bsy_q    <= bsy_d;
    end
  end

  assign bus.clk_en     = clk_en_q;
  assign bus.running    = run_st_q;
  assign bus.burst_busy = bsy_q;
  assign bus.step_count = cnt_q;
endmodule

// File: tb/tb_clk_en_sequencer.sv
// Scoreboard bench for clk_en_sequencer: expected pulse
// cycles are queued at stimulus time and popped per clk_en.
module tb_clk_en_sequencer;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_q[$];
  int   exp_cnt;
  int   k;

  clk_en_sequencer_if #(.DIV_W(16), .CNT_W(8)) bus ();

  clk_en_sequencer #(.DIV_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  task automatic push(input int c);
    exp_q.push_back(c);
`ifdef STEP_COUNT_SAT_EN
    if (exp_cnt != 255) exp_cnt++;
`else
    exp_cnt = (exp_cnt + 1) % 256;
`endif
  endtask

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.clk_en === 1'b1) begin
      if (exp_q.size() == 0)
        chk("spurious_pulse", cyc, 0);
      else
        chk("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.step_pb = 1'b1;
    bus.run_pb = 1'b0;
    bus.burst_pb = 1'b0;
    bus.div_val = '0;
    bus.burst_len = '0;
    bus.halt = 1'b0;

    // reset values; step held across release
    nwait(3);
    chk("rst_clk_en", bus.clk_en, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_busy", bus.burst_busy, 0);
    chk("rst_count", bus.step_count, 0);
    rst = 1'b0;
    nwait(4);
    bus.step_pb = 1'b0;
    nwait(3);
    chk("held_count", bus.step_count, 0);

    // single step, held 5 cycles
    k = cyc;
    bus.step_pb = 1'b1;
    push(k + 1);
    nwait(5);
    bus.step_pb = 1'b0;
    nwait(4);
    chk("step_count1", bus.step_count, exp_cnt);
    chk("step_running", bus.running, 0);
    chk("step_q", exp_q.size(), 0);

    // free run, div 3
    bus.div_val = 16'd3;
    k = cyc;
    bus.run_pb = 1'b1;
    push(k + 5);
    push(k + 9);
    push(k + 13);
    nwait(2);
    bus.run_pb = 1'b0;
    nwait(1);
    chk("run_running", bus.running, 1);
    nwait(11);
    bus.run_pb = 1'b1;
    nwait(2);
    bus.run_pb = 1'b0;
    nwait(10);
    chk("run_stopped", bus.running, 0);
    chk("run_q", exp_q.size(), 0);
    chk("run_count", bus.step_count, exp_cnt);

    // burst of 5, div 0
    bus.div_val = 16'd0;
    bus.burst_len = 8'd5;
    k = cyc;
    bus.burst_pb = 1'b1;
    for (int i = 2; i <= 6; i++) push(k + i);
    nwait(2);
    chk("burst_busy", bus.burst_busy, 1);
    bus.burst_pb = 1'b0;
    nwait(5);
    chk("burst_done", bus.burst_busy, 0);
    nwait(3);
    chk("burst_q", exp_q.size(), 0);
    chk("burst_count", bus.step_count, exp_cnt);

    // burst_len 0 is ignored
    bus.burst_len = 8'd0;
    bus.burst_pb = 1'b1;
    nwait(2);
    bus.burst_pb = 1'b0;
    nwait(5);
    chk("len0_busy", bus.burst_busy, 0);
    chk("len0_running", bus.running, 0);
    chk("len0_count", bus.step_count, exp_cnt);

    // halt after 3rd pulse of a 10-burst
    bus.div_val = 16'd2;
    bus.burst_len = 8'd10;
    k = cyc;
    bus.burst_pb = 1'b1;
    push(k + 4);
    push(k + 7);
    push(k + 10);
    nwait(2);
    bus.burst_pb = 1'b0;
    nwait(8);
    bus.halt = 1'b1;
    nwait(1);
    chk("halt_busy", bus.burst_busy, 0);
    bus.step_pb = 1'b1;
    bus.run_pb = 1'b1;
    nwait(3);
    bus.step_pb = 1'b0;
    bus.run_pb = 1'b0;
    nwait(3);
    bus.halt = 1'b0;
    nwait(10);
    chk("halt_count", bus.step_count, exp_cnt);
    chk("halt_running", bus.running, 0);
    chk("halt_q", exp_q.size(), 0);

    // run and step same cycle, then reset mid-run
    bus.div_val = 16'd3;
    k = cyc;
    bus.run_pb = 1'b1;
    bus.step_pb = 1'b1;
    push(k + 5);
    nwait(2);
    bus.run_pb = 1'b0;
    bus.step_pb = 1'b0;
    nwait(4);
    chk("both_running", bus.running, 1);
    nwait(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_en", bus.clk_en, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_busy", bus.burst_busy, 0);
    chk("arst_count", bus.step_count, 0);
    exp_cnt = 0;
    nwait(1);
    rst = 1'b0;
    nwait(12);
    chk("arst_q", exp_q.size(), 0);
    chk("arst_idle", bus.running, 0);

    // 257 pulses: wrap or saturate
    bus.div_val = 16'd0;
    k = cyc;
    bus.run_pb = 1'b1;
    for (int i = 2; i <= 258; i++) push(k + i);
    nwait(2);
    bus.run_pb = 1'b0;
    nwait(256);
    bus.run_pb = 1'b1;
    nwait(2);
    bus.run_pb = 1'b0;
    nwait(5);
    chk("wrap_q", exp_q.size(), 0);
    chk("wrap_count", bus.step_count, exp_cnt);
`ifdef STEP_COUNT_SAT_EN
    chk("wrap_abs", bus.step_count, 255);
`else
    chk("wrap_abs", bus.step_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
